// File: rtl/if_prefetch_queue_if.sv
// if_prefetch_queue_if: redirect, instruction-memory and IF-side handshake bundle of the prefetch queue.
interface if_prefetch_queue_if;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_gnt;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;
  logic        inst_valid;
  logic [31:0] inst;
  logic [31:0] inst_pc;
  logic        inst_ready;
  modport master (
    input  redirect, redirect_pc, imem_gnt, imem_rvalid, imem_rdata, inst_ready,
    output imem_req, imem_addr, inst_valid, inst, inst_pc
  );
  modport slave (
    output redirect, redirect_pc, imem_gnt, imem_rvalid, imem_rdata, inst_ready,
    input  imem_req, imem_addr, inst_valid, inst, inst_pc
  );
endinterface

// File: rtl/if_prefetch_queue.sv
// if_prefetch_queue: sequential instruction prefetcher with in-order FIFO and redirect flush.
// Optional PREFETCH_PERF_EN adds saturating discarded-response and empty-cycle counters.
module if_prefetch_queue #(
  parameter int          DEPTH    = 4,
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input logic                 clk,
  input logic                 reset_n,
  if_prefetch_queue_if.master bus
`ifdef PREFETCH_PERF_EN
  ,
  output logic [31:0]         perf_drop_cnt,
  output logic [31:0]         perf_empty_cnt
`endif
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  logic [31:0]   fetch_pc_q, fetch_pc_d, resp_pc_q, resp_pc_d;
  logic [CW-1:0] count_q, count_d, out_q, out_d, drop_q, drop_d;
  logic [AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [31:0]   data_mem [DEPTH];
  logic [31:0]   pc_mem [DEPTH];
  logic [CW:0]   occ;
  logic          valid, issue, rv, drop_rsp, push, pop;
  // Credits cover buffered entries plus live (non-stale) in-flight requests, so the FIFO cannot overflow.
  always_comb begin
    occ            = {1'b0, count_q} + {1'b0, out_q - drop_q};
    valid          = count_q != '0;
    bus.imem_req   = reset_n && !bus.redirect && occ < (CW+1)'(DEPTH);
    bus.imem_addr  = fetch_pc_q;
    bus.inst_valid = valid;
    bus.inst       = valid ? data_mem[rd_ptr_q] : '0;
    bus.inst_pc    = valid ? pc_mem[rd_ptr_q] : '0;
    issue          = bus.imem_req && bus.imem_gnt;
    rv             = bus.imem_rvalid && out_q != '0;
    drop_rsp       = rv && drop_q != '0;
    push           = rv && !drop_rsp && !bus.redirect;
    pop            = valid && bus.inst_ready && !bus.redirect;
    fetch_pc_d     = issue ? fetch_pc_q + 32'd4 : fetch_pc_q;
    resp_pc_d      = push ? resp_pc_q + 32'd4 : resp_pc_q;
    out_d          = out_q + CW'(issue) - CW'(rv);
    drop_d         = drop_rsp ? drop_q - CW'(1) : drop_q;
    count_d        = count_q + CW'(push) - CW'(pop);
    wr_ptr_d       = push ? wr_ptr_q + AW'(1) : wr_ptr_q;
    rd_ptr_d       = pop ? rd_ptr_q + AW'(1) : rd_ptr_q;
    if (bus.redirect) begin
      fetch_pc_d = {bus.redirect_pc[31:2], 2'b00};
      resp_pc_d  = {bus.redirect_pc[31:2], 2'b00};
      out_d      = out_q + CW'(bus.imem_gnt) - CW'(rv);
      drop_d     = out_d;
      count_d    = '0;
      wr_ptr_d   = '0;
      rd_ptr_d   = '0;
    end
  end
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      fetch_pc_q <= RESET_PC;
      resp_pc_q  <= RESET_PC;
      count_q    <= '0;
      out_q      <= '0;
      drop_q     <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
    end else begin
      fetch_pc_q <= fetch_pc_d;
      resp_pc_q  <= resp_pc_d;
      count_q    <= count_d;
      out_q      <= out_d;
      drop_q     <= drop_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
    end
  end
  always_ff @(posedge clk) begin
    if (push) begin
      data_mem[wr_ptr_q] <= bus.imem_rdata;
      pc_mem[wr_ptr_q]   <= resp_pc_q;
    end
  end
`ifdef PREFETCH_PERF_EN
  logic [31:0] perf_drop_q, perf_drop_d, perf_empty_q, perf_empty_d;
  // A response landing in a redirect cycle is discarded even when no drop credit is pending.
  always_comb begin
    perf_drop_d  = rv && (drop_q != '0 || bus.redirect) && perf_drop_q != '1 ? perf_drop_q + 32'd1 : perf_drop_q;
    perf_empty_d = !valid && perf_empty_q != '1 ? perf_empty_q + 32'd1 : perf_empty_q;
  end
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      perf_drop_q  <= '0;
      perf_empty_q <= '0;
    end else begin
      perf_drop_q  <= perf_drop_d;
      perf_empty_q <= perf_empty_d;
    end
  end
  assign perf_drop_cnt  = perf_drop_q;
  assign perf_empty_cnt = perf_empty_q;
`endif
endmodule

// File: tb/tb_if_prefetch_queue.sv
// tb_if_prefetch_queue: directed prefetch scenarios with an in-order memory model and PC scoreboard.
module tb_if_prefetch_queue;
  localparam int DEPTH = 4;
  typedef struct {
    logic [31:0] addr;
    int          due;
    int          epoch;
  } rsp_t;
  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;
  if_prefetch_queue_if bus ();
`ifdef PREFETCH_PERF_EN
  logic [31:0] perf_drop_cnt, perf_empty_cnt;
`endif
  if_prefetch_queue #(.DEPTH(DEPTH), .RESET_PC(32'h0)) dut (
    .clk(clk),
    .reset_n(reset_n),
    .bus(bus)
`ifdef PREFETCH_PERF_EN
    ,
    .perf_drop_cnt(perf_drop_cnt),
    .perf_empty_cnt(perf_empty_cnt)
`endif
  );
  rsp_t        mq[$];
  logic [31:0] exp_q[$];
  logic [31:0] mon_exp;
  int errors = 0, checks = 0, cyc = 0, epoch = 0, resp_epoch = 0;
  int drops = 0, empties = 0, accepts = 0, pops = 0, live = 0, max_live = 0;
  int lat_fix = 1, acc0 = 0;
  bit throttle = 0, lat_rand = 0, ready_rand = 0, ready_on = 1;
  function automatic logic [31:0] mdata(logic [31:0] a);
    return {a[15:0], ~a[31:16]} ^ 32'h5A5A_0F0F;
  endfunction
  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask
  // Memory: drives gnt/rvalid/ready shortly after each rising edge, returning responses in order.
  initial begin
    bus.imem_gnt = 1'b0;
    bus.imem_rvalid = 1'b0;
    bus.imem_rdata = '0;
    bus.inst_ready = 1'b0;
    forever begin
      @(posedge clk);
      #2;
      cyc++;
      bus.inst_ready = ready_rand ? ($urandom_range(0, 3) != 0) : ready_on;
      bus.imem_gnt = throttle ? 1'($urandom_range(0, 1)) : 1'b1;
      if (mq.size() > 0 && mq[0].due <= cyc) begin
        bus.imem_rvalid = 1'b1;
        bus.imem_rdata = mdata(mq[0].addr);
        resp_epoch = mq[0].epoch;
        void'(mq.pop_front());
      end else begin
        bus.imem_rvalid = 1'b0;
        bus.imem_rdata = '0;
      end
    end
  end
  // Acceptance bookkeeping; a gnt in a redirect cycle is an accepted (stale) request.
  always @(negedge clk) begin
    if (reset_n) begin
      if (bus.imem_rvalid && (resp_epoch != epoch || bus.redirect)) drops++;
      if (!bus.inst_valid) empties++;
      if (bus.imem_gnt && (bus.imem_req || bus.redirect)) begin
        mq.push_back('{addr: bus.imem_addr, due: cyc + (lat_rand ? int'($urandom_range(1, 5)) : lat_fix), epoch: epoch});
        accepts++;
      end
      if (bus.redirect) epoch++;
      live = 0;
      foreach (mq[i]) if (mq[i].epoch == epoch) live++;
      if (live > max_live) max_live = live;
    end
  end
  always @(negedge clk) begin
    if (reset_n && bus.inst_valid && bus.inst_ready && !bus.redirect) begin
      pops++;
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_pop: got pc %h expected none", bus.inst_pc);
      end else begin
        mon_exp = exp_q.pop_front();
        check("inst_pc", bus.inst_pc, mon_exp);
        check("inst", bus.inst, mdata(mon_exp));
      end
    end
  end
  task automatic tick(int n = 1);
    repeat (n) @(posedge clk);
    #1;
  endtask
  task automatic expect_from(logic [31:0] pc);
    exp_q.delete();
    for (int i = 0; i < 400; i++) exp_q.push_back({pc[31:2], 2'b00} + 32'(4 * i));
  endtask
  task automatic redir(logic [31:0] pc);
    bus.redirect = 1'b1;
    bus.redirect_pc = pc;
    expect_from(pc);
    tick();
    bus.redirect = 1'b0;
  endtask
  initial begin
    bus.redirect = 1'b0;
    bus.redirect_pc = '0;
    expect_from(32'h0);
    tick(3);
    @(negedge clk);
    check("rst_imem_req", 32'(bus.imem_req), 32'h0);
    check("rst_inst_valid", 32'(bus.inst_valid), 32'h0);
    check("rst_inst", bus.inst, 32'h0);
    check("rst_inst_pc", bus.inst_pc, 32'h0);
    tick();
    reset_n = 1'b1;
    @(negedge clk);
    check("run_req0", 32'(bus.imem_req), 32'h1);
    check("run_addr0", bus.imem_addr, 32'h0);
    check("run_valid0", 32'(bus.inst_valid), 32'h0);
    tick();
    @(negedge clk);
    check("run_addr1", bus.imem_addr, 32'h4);
    check("run_valid1", 32'(bus.inst_valid), 32'h0);
    tick();
    @(negedge clk);
    check("run_addr2", bus.imem_addr, 32'h8);
    check("run_valid2", 32'(bus.inst_valid), 32'h1);
    tick(20);
    ready_on = 1'b0;
    redir(32'h200);
    acc0 = accepts;
    tick(10);
    check("stall_issued", 32'(accepts - acc0), 32'd4);
    @(negedge clk);
    check("stall_req", 32'(bus.imem_req), 32'h0);
    check("stall_valid", 32'(bus.inst_valid), 32'h1);
    check("stall_head", bus.inst_pc, 32'h200);
    tick();
    ready_on = 1'b1;
    tick();
    @(negedge clk);
    check("resume_req", 32'(bus.imem_req), 32'h1);
    tick(10);
    lat_fix = 2;
    tick(10);
    redir(32'h0000_0103);
    @(negedge clk);
    check("redir_addr", bus.imem_addr, 32'h100);
    check("redir_req", 32'(bus.imem_req), 32'h1);
    check("redir_empty", 32'(bus.inst_valid), 32'h0);
    tick(15);
    bus.redirect = 1'b1;
    bus.redirect_pc = 32'h300;
    expect_from(32'h300);
    tick();
    bus.redirect_pc = 32'h400;
    expect_from(32'h400);
    tick();
    bus.redirect = 1'b0;
    @(negedge clk);
    check("b2b_addr", bus.imem_addr, 32'h400);
    check("b2b_empty", 32'(bus.inst_valid), 32'h0);
    tick(15);
    throttle = 1'b1;
    lat_rand = 1'b1;
    ready_rand = 1'b1;
    redir(32'h1000);
    tick(150);
    redir(32'h2000);
    tick(150);
    throttle = 1'b0;
    lat_rand = 1'b0;
    ready_rand = 1'b0;
    lat_fix = 1;
    tick(15);
    redir(32'hFFFF_FFFC);
    @(negedge clk);
    check("wrap_addr0", bus.imem_addr, 32'hFFFF_FFFC);
    tick();
    @(negedge clk);
    check("wrap_addr1", bus.imem_addr, 32'h0);
    tick(12);
    @(negedge clk);
    check("max_live_inflight", 32'(max_live <= DEPTH), 32'h1);
    check("enough_pops", 32'(pops >= 100), 32'h1);
`ifdef PREFETCH_PERF_EN
    check("perf_drop_cnt", perf_drop_cnt, 32'(drops));
    check("perf_empty_cnt", perf_empty_cnt, 32'(empties));
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
